// File: rtl/ahb_decode_resp_mux.sv
// ahb_decode_resp_mux: AHB address decoder, data-phase slave response mux and saturating error counter
module ahb_decode_resp_mux #(
  parameter int                          SLV_NUM  = 4,
  parameter int                          ADDR_W   = 32,
  parameter int                          DATA_W   = 32,
  parameter logic [SLV_NUM*ADDR_W-1:0]   SLV_BASE = '0,
  parameter logic [SLV_NUM*ADDR_W-1:0]   SLV_MASK = {SLV_NUM{32'hF000_0000}},
  parameter int                          CNT_W    = 8
) (
  input  logic                        hclk,
  input  logic                        hreset_n,
  input  logic [ADDR_W-1:0]           haddr,
  input  logic [1:0]                  htrans,
  output logic [SLV_NUM-1:0]          hsel,
  output logic                        default_slv_sel,
  input  logic [SLV_NUM*DATA_W-1:0]   slv_hrdata,
  input  logic [SLV_NUM-1:0]          slv_hreadyout,
  input  logic [SLV_NUM-1:0]          slv_hresp,
  input  logic                        def_hreadyout,
  input  logic                        def_hresp,
  output logic                        hready,
  output logic                        hresp,
  output logic [DATA_W-1:0]           hrdata,
  output logic [CNT_W-1:0]            err_cnt,
  input  logic                        err_cnt_clr
);
  localparam int            IW   = $clog2(SLV_NUM + 2);
  localparam logic [IW-1:0] DEF  = IW'(SLV_NUM);
  localparam logic [IW-1:0] NONE = IW'(SLV_NUM + 1);
  logic [IW-1:0]    hit_idx, dsel_d, dsel_q;
  logic             hit;
  logic [CNT_W-1:0] err_cnt_d, err_cnt_q;
  logic             unused;
  assign unused = htrans[0];
  // Descending scan so the lowest matching index is the one left standing
  always_comb begin
    hit = 1'b0;
    hit_idx = NONE;
    for (int i = SLV_NUM - 1; i >= 0; i--)
      if ((haddr & SLV_MASK[i*ADDR_W +: ADDR_W]) == (SLV_BASE[i*ADDR_W +: ADDR_W] & SLV_MASK[i*ADDR_W +: ADDR_W])) begin
        hit = 1'b1;
        hit_idx = IW'(i);
      end
  end
  assign hsel            = (htrans[1] && hit) ? SLV_NUM'(1) << hit_idx : '0;
  assign default_slv_sel = htrans[1] && !hit;
  assign dsel_d          = !htrans[1] ? NONE : hit ? hit_idx : DEF;
  always_ff @(posedge hclk or negedge hreset_n)
    if (!hreset_n) dsel_q <= NONE;
    else if (hready) dsel_q <= dsel_d;
  always_comb begin
    hready = dsel_q == DEF ? def_hreadyout : 1'b1;
    hresp  = dsel_q == DEF ? def_hresp : 1'b0;
    hrdata = '0;
    for (int i = 0; i < SLV_NUM; i++)
      if (dsel_q == IW'(i)) begin
        hready = slv_hreadyout[i];
        hresp  = slv_hresp[i];
        hrdata = slv_hrdata[i*DATA_W +: DATA_W];
      end
  end
  assign err_cnt_d = err_cnt_clr ? '0 :
                     (hready && hresp && err_cnt_q != '1) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
  always_ff @(posedge hclk or negedge hreset_n)
    if (!hreset_n) err_cnt_q <= '0;
    else err_cnt_q <= err_cnt_d;
  assign err_cnt = err_cnt_q;
endmodule

// File: tb/tb_ahb_decode_resp_mux.sv
// tb_ahb_decode_resp_mux: decode vector table, directed multi-cycle sequences and randomized model comparison
module tb_ahb_decode_resp_mux;
  localparam logic [127:0] BASE = {32'h3000_0000, 32'h0000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [127:0] MASK = {32'hF000_0000, 32'hFF00_0000, 32'hF000_0000, 32'hF000_0000};
  logic         clk, hreset_n;
  logic [31:0]  haddr;
  logic [1:0]   htrans;
  logic [3:0]   hsel;
  logic         default_slv_sel;
  logic [127:0] slv_hrdata;
  logic [3:0]   slv_hreadyout, slv_hresp;
  logic         def_hreadyout, def_hresp;
  logic         hready, hresp;
  logic [31:0]  hrdata;
  logic [1:0]   err_cnt;
  logic         err_cnt_clr;
  int checks = 0;
  int passed = 0;
  int m_dsel, m_cnt, idx;
  logic [31:0] bases [4];
  logic [31:0] masks [4];
  logic        exp_hready, exp_hresp;
  logic [31:0] exp_hrdata;

  ahb_decode_resp_mux #(.SLV_NUM(4), .ADDR_W(32), .DATA_W(32), .SLV_BASE(BASE), .SLV_MASK(MASK), .CNT_W(2)) dut (
    .hclk(clk), .hreset_n(hreset_n), .haddr(haddr), .htrans(htrans), .hsel(hsel),
    .default_slv_sel(default_slv_sel), .slv_hrdata(slv_hrdata), .slv_hreadyout(slv_hreadyout),
    .slv_hresp(slv_hresp), .def_hreadyout(def_hreadyout), .def_hresp(def_hresp), .hready(hready),
    .hresp(hresp), .hrdata(hrdata), .err_cnt(err_cnt), .err_cnt_clr(err_cnt_clr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic [3:0]  exp_hsel;
    logic        exp_def;
  } vec_t;
  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lowest-index matching region, 4 meaning "no region" (default slave)
  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if ((a & masks[i]) == (bases[i] & masks[i])) return i;
    return 4;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      bases[i] = BASE[i*32 +: 32];
      masks[i] = MASK[i*32 +: 32];
    end
    vecs[0] = '{32'h1000_0040, 2'b10, 4'b0010, 1'b0};
    vecs[1] = '{32'h0012_3456, 2'b10, 4'b0001, 1'b0};
    vecs[2] = '{32'h0012_3456, 2'b00, 4'b0000, 1'b0};
    vecs[3] = '{32'h0012_3456, 2'b01, 4'b0000, 1'b0};
    vecs[4] = '{32'h0512_0000, 2'b11, 4'b0001, 1'b0};
    vecs[5] = '{32'h3FFF_FFFC, 2'b11, 4'b1000, 1'b0};
    vecs[6] = '{32'hF000_0000, 2'b10, 4'b0000, 1'b1};
    vecs[7] = '{32'h2000_0000, 2'b10, 4'b0000, 1'b1};
    vecs[8] = '{32'hF000_0000, 2'b00, 4'b0000, 1'b0};
    haddr = '0; htrans = '0; slv_hrdata = '0; slv_hreadyout = '1; slv_hresp = '0;
    def_hreadyout = 1'b1; def_hresp = 1'b0; err_cnt_clr = 1'b0; hreset_n = 1'b0;
    #3;
    chk("reset_hready", hready, 1);
    chk("reset_hresp", hresp, 0);
    chk("reset_hrdata", hrdata, 0);
    chk("reset_err_cnt", err_cnt, 0);
    for (int v = 0; v < 9; v++) begin
      haddr = vecs[v].addr;
      htrans = vecs[v].trans;
      #1;
      chk($sformatf("vec%0d_hsel", v), hsel, vecs[v].exp_hsel);
      chk($sformatf("vec%0d_default_sel", v), default_slv_sel, vecs[v].exp_def);
    end
    htrans = 2'b00;
    @(negedge clk) hreset_n = 1'b1;
    tick();
    // Decode to slave 1 and read its data in the data phase
    haddr = 32'h1000_0040; htrans = 2'b10; #1;
    chk("seqA_hsel", hsel, 4'b0010);
    tick();
    htrans = 2'b00; slv_hrdata[63:32] = 32'hCAFE_0001; #1;
    chk("seqA_hrdata", hrdata, 32'hCAFE_0001);
    chk("seqA_hready", hready, 1);
    tick();
    // Slave 3 inserts three wait states while slave 0 is requested
    haddr = 32'h3000_0000; htrans = 2'b10;
    tick();
    slv_hreadyout[3] = 1'b0; slv_hrdata[127:96] = 32'h3333_3333; haddr = 32'h0000_0100; #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("seqB_wait%0d_hready", k), hready, 0);
      chk($sformatf("seqB_wait%0d_hrdata", k), hrdata, 32'h3333_3333);
      chk($sformatf("seqB_wait%0d_hsel", k), hsel, 4'b0001);
      tick();
    end
    slv_hreadyout[3] = 1'b1; #1;
    chk("seqB_release_hready", hready, 1);
    tick();
    htrans = 2'b00; slv_hrdata[31:0] = 32'h0000_AAAA; #1;
    chk("seqB_slv0_hrdata", hrdata, 32'h0000_AAAA);
    tick();
    // Default slave two-cycle ERROR
    haddr = 32'hF000_0000; htrans = 2'b10; #1;
    chk("seqC_default_sel", default_slv_sel, 1);
    chk("seqC_hsel", hsel, 0);
    tick();
    htrans = 2'b00; def_hreadyout = 1'b0; def_hresp = 1'b1; #1;
    chk("seqC_err1_hresp", hresp, 1);
    chk("seqC_err1_hready", hready, 0);
    chk("seqC_err1_hrdata", hrdata, 0);
    tick();
    chk("seqC_cnt_hold", err_cnt, 0);
    def_hreadyout = 1'b1; #1;
    chk("seqC_err2_hresp", hresp, 1);
    chk("seqC_err2_hready", hready, 1);
    tick();
    def_hresp = 1'b0; #1;
    chk("seqC_cnt_one", err_cnt, 1);
    chk("seqC_back_none", hready, 1);
    // Back-to-back errors saturate the 2-bit counter, then clear wins
    haddr = 32'hF000_0000; htrans = 2'b10; def_hresp = 1'b1;
    tick();
    repeat (5) tick();
    chk("cnt_saturate", err_cnt, 3);
    err_cnt_clr = 1'b1;
    tick();
    err_cnt_clr = 1'b0; #1;
    chk("cnt_clr_priority", err_cnt, 0);
    tick();
    chk("cnt_resume", err_cnt, 1);
    htrans = 2'b00; def_hresp = 1'b0;
    tick();
    // Asynchronous reset in the middle of a wait state
    haddr = 32'h3000_0000; htrans = 2'b10;
    tick();
    htrans = 2'b00; slv_hreadyout[3] = 1'b0; slv_hresp[3] = 1'b1; slv_hrdata[127:96] = 32'h5A5A_5A5A; #1;
    chk("rst_mid_pre_hready", hready, 0);
    hreset_n = 1'b0; #1;
    chk("rst_mid_hready", hready, 1);
    chk("rst_mid_hresp", hresp, 0);
    chk("rst_mid_hrdata", hrdata, 0);
    chk("rst_mid_err_cnt", err_cnt, 0);
    slv_hreadyout = '1; slv_hresp = '0;
    @(negedge clk) hreset_n = 1'b1;
    tick();
    // Randomized traffic against the reference model
    m_dsel = -1;
    m_cnt = 0;
    repeat (300) begin
      haddr = $urandom;
      case ($urandom_range(0, 5))
        0: haddr[31:24] = 8'h00;
        1: haddr[31:28] = 4'h0;
        2: haddr[31:28] = 4'h1;
        3: haddr[31:28] = 4'h3;
        4: haddr[31:28] = 4'h2;
        default: haddr[31:28] = 4'hF;
      endcase
      htrans = 2'($urandom_range(0, 3));
      slv_hrdata = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < 4; i++) slv_hreadyout[i] = $urandom_range(0, 3) != 0;
      slv_hresp = 4'($urandom);
      def_hreadyout = $urandom_range(0, 3) != 0;
      def_hresp = 1'($urandom);
      err_cnt_clr = $urandom_range(0, 15) == 0;
      #1;
      idx = decode(haddr);
      exp_hready = m_dsel < 0 ? 1'b1 : m_dsel == 4 ? def_hreadyout : slv_hreadyout[m_dsel];
      exp_hresp  = m_dsel < 0 ? 1'b0 : m_dsel == 4 ? def_hresp : slv_hresp[m_dsel];
      exp_hrdata = (m_dsel >= 0 && m_dsel < 4) ? slv_hrdata[m_dsel*32 +: 32] : 32'h0;
      chk("rnd_hsel", hsel, (htrans[1] && idx < 4) ? 4'(1 << idx) : 4'h0);
      chk("rnd_default_sel", default_slv_sel, htrans[1] && idx == 4);
      chk("rnd_hready", hready, exp_hready);
      chk("rnd_hresp", hresp, exp_hresp);
      chk("rnd_hrdata", hrdata, exp_hrdata);
      chk("rnd_err_cnt", err_cnt, m_cnt);
      if (err_cnt_clr) m_cnt = 0;
      else if (exp_hready && exp_hresp) m_cnt = m_cnt < 3 ? m_cnt + 1 : 3;
      if (exp_hready) m_dsel = htrans[1] ? idx : -1;
      tick();
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
